// File: rtl/sap1_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sap1_ctrl_pkg
// Shared definitions for the SAP-1 control sequencer:
//   - opcode constants (upper nibble of the instruction register)
//   - control-word bit indices (HLT=15 ... FI=0)
//   - flag bit positions within {carry, zero}
//   - sequencer state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package sap1_ctrl_pkg;

    localparam int CTRL_W = 16;

    // Opcodes
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit indices
    localparam int CB_HLT = 15;
    localparam int CB_MI  = 14;
    localparam int CB_RI  = 13;
    localparam int CB_RO  = 12;
    localparam int CB_IO  = 11;
    localparam int CB_II  = 10;
    localparam int CB_AI  = 9;
    localparam int CB_AO  = 8;
    localparam int CB_EO  = 7;
    localparam int CB_SU  = 6;
    localparam int CB_BI  = 5;
    localparam int CB_OI  = 4;
    localparam int CB_CE  = 3;
    localparam int CB_CO  = 2;
    localparam int CB_J   = 1;
    localparam int CB_FI  = 0;

    // Flag positions within i_flags = {carry, zero}
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_ZERO  = 0;

    // Encoding chosen so that bit 0 is "paused" and bit 1 is "halted";
    // the status outputs are then plain register bits.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PAUSE = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

endpackage

// File: rtl/sap1_microcode_rom.sv
// -----------------------------------------------------------------------------
// sap1_microcode_rom
// Purely combinational microcode table. Maps (opcode, step, flags) to the
// 16-bit control word and a flag marking the final T-state of the instruction.
// Ports:
//   i_opcode    in  4           instruction opcode
//   i_step      in  STEP_WIDTH  current T-state
//   i_flags     in  2           {carry, zero}
//   o_ctrl      out 16          control word for this T-state
//   o_last_step out 1           this T-state ends the instruction
// -----------------------------------------------------------------------------
module sap1_microcode_rom
    import sap1_ctrl_pkg::*;
#(
    parameter int INSTRUCTION_STEPS = 5,
    parameter int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic [3:0]            i_opcode,
    input  logic [STEP_WIDTH-1:0] i_step,
    input  logic [1:0]            i_flags,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic                  o_last_step
);

    localparam logic [STEP_WIDTH-1:0] T0       = STEP_WIDTH'(0);
    localparam logic [STEP_WIDTH-1:0] T1       = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] T2       = STEP_WIDTH'(2);
    localparam logic [STEP_WIDTH-1:0] T3       = STEP_WIDTH'(3);
    localparam logic [STEP_WIDTH-1:0] T4       = STEP_WIDTH'(4);
    localparam logic [STEP_WIDTH-1:0] STEP_MAX = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    logic [STEP_WIDTH-1:0] w_last_idx;

    always_comb begin
        o_ctrl = '0;
        case (i_step)
            T0: begin
                o_ctrl[CB_CO] = 1'b1;
                o_ctrl[CB_MI] = 1'b1;
            end
            T1: begin
                o_ctrl[CB_RO] = 1'b1;
                o_ctrl[CB_II] = 1'b1;
                o_ctrl[CB_CE] = 1'b1;
            end
            T2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_ctrl[CB_IO] = 1'b1;
                        o_ctrl[CB_MI] = 1'b1;
                    end
                    OP_LDI: begin
                        o_ctrl[CB_IO] = 1'b1;
                        o_ctrl[CB_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        o_ctrl[CB_IO] = 1'b1;
                        o_ctrl[CB_J]  = 1'b1;
                    end
                    OP_JC: begin
                        o_ctrl[CB_IO] = i_flags[FLAG_CARRY];
                        o_ctrl[CB_J]  = i_flags[FLAG_CARRY];
                    end
                    OP_JZ: begin
                        o_ctrl[CB_IO] = i_flags[FLAG_ZERO];
                        o_ctrl[CB_J]  = i_flags[FLAG_ZERO];
                    end
                    OP_OUT: begin
                        o_ctrl[CB_AO] = 1'b1;
                        o_ctrl[CB_OI] = 1'b1;
                    end
                    OP_HLT: o_ctrl[CB_HLT] = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl[CB_RO] = 1'b1;
                        o_ctrl[CB_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_ctrl[CB_RO] = 1'b1;
                        o_ctrl[CB_BI] = 1'b1;
                    end
                    OP_STA: begin
                        o_ctrl[CB_AO] = 1'b1;
                        o_ctrl[CB_RI] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                    o_ctrl[CB_EO] = 1'b1;
                    o_ctrl[CB_AI] = 1'b1;
                    o_ctrl[CB_FI] = 1'b1;
                    o_ctrl[CB_SU] = (i_opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_opcode)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: w_last_idx = T2;
            OP_LDA, OP_STA:                               w_last_idx = T3;
            OP_ADD, OP_SUB:                               w_last_idx = T4;
            default:                                      w_last_idx = T1;
        endcase
    end

    // ">=" rather than "==": if the opcode changes mid-instruction and the
    // step is already past the new opcode's end, the sequencer still wraps
    // instead of running on. The STEP_MAX term bounds the counter explicitly.
    assign o_last_step = (i_step >= w_last_idx) || (i_step >= STEP_MAX);

endmodule

// File: rtl/sap1_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_control_sequencer
// SAP-1 microcode control sequencer: T-state counter plus RUN/PAUSE/HALT FSM,
// with the control word decoded combinationally from the registered step.
// State updates on the falling edge of mclk so o_ctrl is settled before the
// rising edge where the datapath consumes it.
// Ports:
//   mclk          in  1           master clock (state updates on falling edge)
//   i_reset       in  1           synchronous active-high reset (ignores mclk_en)
//   mclk_en       in  1           clock enable; low freezes all state
//   i_opcode      in  4           instruction register upper nibble
//   i_flags       in  2           {carry, zero}
//   i_single_step in  1           pause after every completed instruction
//   i_step        in  1           releases a pause (qualified by mclk_en)
//   o_ctrl        out 16          control word {HLT,MI,RI,RO,IO,II,AI,AO,
//                                               EO,SU,BI,OI,CE,CO,J,FI}
//   o_step        out STEP_WIDTH  current T-state
//   o_halted      out 1           sequencer is halted
//   o_paused      out 1           sequencer is paused
// -----------------------------------------------------------------------------
module sap1_control_sequencer
    import sap1_ctrl_pkg::*;
#(
    parameter  int INSTRUCTION_STEPS = 5,
    localparam int STEP_WIDTH        = $clog2(INSTRUCTION_STEPS)
) (
    input  logic                  mclk,
    input  logic                  i_reset,
    input  logic                  mclk_en,
    input  logic [3:0]            i_opcode,
    input  logic [1:0]            i_flags,
    input  logic                  i_single_step,
    input  logic                  i_step,
    output logic [CTRL_W-1:0]     o_ctrl,
    output logic [STEP_WIDTH-1:0] o_step,
    output logic                  o_halted,
    output logic                  o_paused
);

    generate
        if (INSTRUCTION_STEPS < 5) begin : g_bad_steps
            $error("sap1_control_sequencer: INSTRUCTION_STEPS must be >= 5");
        end
    endgenerate

    state_e                r_state;
    logic [STEP_WIDTH-1:0] r_step;

    logic [CTRL_W-1:0]     w_rom_ctrl;
    logic                  w_last_step;
    logic [STEP_WIDTH-1:0] w_step_inc;

    sap1_microcode_rom #(
        .INSTRUCTION_STEPS (INSTRUCTION_STEPS),
        .STEP_WIDTH        (STEP_WIDTH)
    ) u_rom (
        .i_opcode    (i_opcode),
        .i_step      (r_step),
        .i_flags     (i_flags),
        .o_ctrl      (w_rom_ctrl),
        .o_last_step (w_last_step)
    );

    assign w_step_inc = r_step + STEP_WIDTH'(1);

    always_ff @(negedge mclk) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_step  <= '0;
        end else if (mclk_en) begin
            case (r_state)
                ST_RUN: begin
                    // HLT is only decoded at T2; the step stays there while halted.
                    if (w_rom_ctrl[CB_HLT]) begin
                        r_state <= ST_HALT;
                    end else if (w_last_step) begin
                        r_step <= '0;
                        if (i_single_step) begin
                            r_state <= ST_PAUSE;
                        end
                    end else begin
                        r_step <= w_step_inc;
                    end
                end
                ST_PAUSE: begin
                    if (i_step) begin
                        r_state <= ST_RUN;
                        r_step  <= '0;
                    end
                end
                ST_HALT: ;
                default: begin
                    r_state <= ST_RUN;
                    r_step  <= '0;
                end
            endcase
        end
    end

    assign o_ctrl   = (r_state == ST_RUN) ? w_rom_ctrl : '0;
    assign o_step   = r_step;
    assign o_halted = r_state[1];
    assign o_paused = r_state[0];

endmodule
